// File: rtl/fir_param_pkg.sv
// Shared types for the parameterised FIR filter: the FSM state encoding and the
// accumulator sizing rule.
package fir_param_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    MAC   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Product width plus enough headroom to sum NUM_TAPS products, plus a sign bit.
  function automatic int acc_width(input int data_w, input int num_taps);
    return 2 * data_w + $clog2(num_taps) + 1;
  endfunction

endpackage

// File: rtl/fir_sample_counter.sv
// Counts completed samples 0..SAMPLE_CNT-1 and emits a one-cycle registered pulse
// on the completion that wraps the count back to zero.
module fir_sample_counter #(
  parameter int SAMPLE_CNT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic wrap_o
);

  localparam int CNT_W = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (count_en_i) begin
        if (cnt_q == CNT_W'(SAMPLE_CNT - 1)) begin
          cnt_q  <= '0;
          wrap_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign wrap_o = wrap_q;

endmodule

// File: rtl/fir_filter_param.sv
// Sequential single-multiplier FIR: alternating-sign taps, saturated magnitude output,
// synchronised edge-triggered requests, sticky error on overflow or dropped requests.
module fir_filter_param
  import fir_param_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_TAPS   = 4,
  parameter int COEF_FRAC  = 15,
  parameter int SAMPLE_CNT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] fir_coefficient,
  input  logic              data_ready,
  input  logic              load_coeff,
  output logic [DATA_W-1:0] fir_out,
  output logic              modwait,
  output logic              one_k_samples,
  output logic              err
);

  localparam int ACC_W  = acc_width(DATA_W, NUM_TAPS);
  localparam int PROD_W = 2 * DATA_W;
  localparam int TAP_W  = $clog2(NUM_TAPS);

  logic [2:0]              dr_sync_q, lc_sync_q;
  logic                    dr_edge, lc_edge, any_edge;
  state_e                  state_q;
  logic [TAP_W-1:0]        tap_q, idx_q;
  logic [DATA_W-1:0]       coef_q [NUM_TAPS];
  logic [DATA_W-1:0]       x_q    [NUM_TAPS];
  logic signed [ACC_W-1:0] acc_q;
  logic                    col_q, modwait_q, err_q;
  logic [DATA_W-1:0]       fir_out_q;

  logic [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]        acc_abs, mag;
  logic                    sat_d;
  logic [DATA_W-1:0]       fir_out_d;

  // Bits [1:0] synchronise; bit 2 is the previous synchronised level for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dr_sync_q <= '0;
      lc_sync_q <= '0;
    end else begin
      dr_sync_q <= {dr_sync_q[1:0], data_ready};
      lc_sync_q <= {lc_sync_q[1:0], load_coeff};
    end
  end

  assign dr_edge  = dr_sync_q[1] & ~dr_sync_q[2];
  assign lc_edge  = lc_sync_q[1] & ~lc_sync_q[2];
  assign any_edge = dr_edge | lc_edge;

  assign prod     = PROD_W'(x_q[tap_q]) * PROD_W'(coef_q[tap_q]);
  assign prod_ext = $signed({{(ACC_W - PROD_W){1'b0}}, prod});

  always_comb begin
    acc_abs   = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
    mag       = acc_abs >> COEF_FRAC;
    sat_d     = |mag[ACC_W-1:DATA_W];
    fir_out_d = sat_d ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      col_q     <= 1'b0;
      modwait_q <= 1'b0;
      err_q     <= 1'b0;
      fir_out_q <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_q[k] <= '0;
        x_q[k]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (lc_edge) begin
            coef_q[idx_q] <= fir_coefficient;
            idx_q         <= (idx_q == TAP_W'(NUM_TAPS - 1)) ? '0 : idx_q + 1'b1;
            modwait_q     <= 1'b1;
            state_q       <= LOAD;
            if (dr_edge) err_q <= 1'b1;
          end else if (dr_edge) begin
            for (int k = 1; k < NUM_TAPS; k++) x_q[k] <= x_q[k-1];
            x_q[0]    <= sample_data;
            acc_q     <= '0;
            col_q     <= 1'b0;
            modwait_q <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        LOAD: begin
          if (any_edge) err_q <= 1'b1;
          modwait_q <= 1'b0;
          state_q   <= IDLE;
        end
        SHIFT: begin
          if (any_edge) begin
            err_q <= 1'b1;
            col_q <= 1'b1;
          end
          tap_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          if (any_edge) begin
            err_q <= 1'b1;
            col_q <= 1'b1;
          end
          acc_q <= tap_q[0] ? acc_q - prod_ext : acc_q + prod_ext;
          if (tap_q == TAP_W'(NUM_TAPS - 1)) state_q <= DONE;
          else tap_q <= tap_q + 1'b1;
        end
        DONE: begin
          fir_out_q <= fir_out_d;
          modwait_q <= 1'b0;
          state_q   <= IDLE;
          // A collision landing in this very cycle still counts against the clear.
          if (sat_d || any_edge) err_q <= 1'b1;
          else if (!col_q) err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fir_sample_counter #(
    .SAMPLE_CNT(SAMPLE_CNT)
  ) u_sample_counter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   ((state_q == IDLE) && lc_edge),
    .count_en_i(state_q == DONE),
    .wrap_o    (one_k_samples)
  );

  assign fir_out = fir_out_q;
  assign modwait = modwait_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed-vector bench for fir_filter_param with a queue scoreboard popped on each
// completed operation (falling modwait).
module tb_fir_filter_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_data = '0;
  logic [15:0] fir_coefficient = '0;
  logic        data_ready = 1'b0;
  logic        load_coeff = 1'b0;
  logic [15:0] fir_out;
  logic        modwait, one_k_samples, err;

  typedef struct packed {
    logic [15:0] out;
    logic        err;
    logic        onek;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;
  logic prev_mw = 1'b0;

  fir_filter_param #(
    .DATA_W(16), .NUM_TAPS(4), .COEF_FRAC(15), .SAMPLE_CNT(4)
  ) dut (
    .clk(clk), .reset(reset), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .data_ready(data_ready), .load_coeff(load_coeff), .fir_out(fir_out),
    .modwait(modwait), .one_k_samples(one_k_samples), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every completed operation must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_mw = modwait;
    end else begin
      if (one_k_samples) pulses++;
      if (prev_mw && !modwait) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_op: out=0x%0h err=%0b with no expectation queued", fir_out, err);
        end else begin
          e = sb.pop_front();
          if (fir_out !== e.out || err !== e.err || one_k_samples !== e.onek) begin
            miscompares++;
            $display("FAIL op_result: got out=0x%0h err=%0b onek=%0b, expected out=0x%0h err=%0b onek=%0b",
                     fir_out, err, one_k_samples, e.out, e.err, e.onek);
          end
        end
      end
      prev_mw = modwait;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic do_ld, input logic do_dr, input logic [15:0] c, input logic [15:0] s);
    @(negedge clk);
    fir_coefficient = c;
    sample_data     = s;
    load_coeff      = do_ld;
    data_ready      = do_dr;
    @(negedge clk);
    load_coeff = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic load(input logic [15:0] c, input logic [15:0] eo, input logic ee);
    sb.push_back('{eo, ee, 1'b0});
    pulse(1'b1, 1'b0, c, 16'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic sample(input logic [15:0] s, input logic [15:0] eo, input logic ee, input logic ek);
    sb.push_back('{eo, ee, ek});
    pulse(1'b0, 1'b1, fir_coefficient, s);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_fir_out", fir_out, 0);
    check("rst_modwait", modwait, 0);
    check("rst_err", err, 0);
    check("rst_onek", one_k_samples, 0);

    // Unit coefficient on tap 0; exact latency and modwait window of one sample.
    load(16'h8000, 16'd0, 1'b0);
    load(16'h0000, 16'd0, 1'b0);
    load(16'h0000, 16'd0, 1'b0);
    load(16'h0000, 16'd0, 1'b0);
    sb.push_back('{16'd100, 1'b0, 1'b0});
    @(negedge clk);
    sample_data = 16'd100;
    data_ready  = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("lat_modwait_%0d", k), modwait, (k >= 3 && k <= 8) ? 1 : 0);
      check($sformatf("lat_fir_out_%0d", k), fir_out, (k == 9) ? 100 : 0);
    end
    repeat (4) @(negedge clk);

    // Simultaneous edges: load wins (coef0 = 0.5), data request dropped, err set.
    sb.push_back('{16'd100, 1'b1, 1'b0});
    pulse(1'b1, 1'b1, 16'h4000, 16'd999);
    repeat (6) @(negedge clk);
    sample(16'd200, 16'd100, 1'b0, 1'b0);

    // Second request two cycles after the accepted one: dropped, err set, one result.
    sb.push_back('{16'd25, 1'b1, 1'b0});
    @(negedge clk);
    sample_data = 16'd50;
    data_ready  = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("col_queue_empty", sb.size(), 0);

    // Reset in the middle of the MAC phase.
    @(negedge clk);
    sample_data = 16'd7;
    data_ready  = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_mac_modwait", modwait, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_fir_out", fir_out, 0);
    check("rst_mid_modwait", modwait, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_onek", one_k_samples, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_fir_out", fir_out, 0);
    check("post_rst_modwait", modwait, 0);

    // Saturation sets err; a clean sample afterwards clears it.
    do_reset();
    load(16'hFFFF, 16'd0, 1'b0);
    load(16'h0000, 16'd0, 1'b0);
    load(16'h0000, 16'd0, 1'b0);
    load(16'h0000, 16'd0, 1'b0);
    sample(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    load(16'h8000, 16'hFFFF, 1'b1);
    sample(16'd1, 16'd1, 1'b0, 1'b0);

    // Alternating signs with all taps at 1.0; fourth sample wraps the counter.
    do_reset();
    for (int i = 0; i < 4; i++) load(16'h8000, 16'd0, 1'b0);
    sample(16'd400, 16'd400, 1'b0, 1'b0);
    sample(16'd300, 16'd100, 1'b0, 1'b0);
    sample(16'd200, 16'd300, 1'b0, 1'b0);
    sample(16'd100, 16'd200, 1'b0, 1'b1);

    // Nine samples: wrap pulses on the 4th and 8th only.
    do_reset();
    for (int i = 1; i <= 9; i++) sample(16'd10, 16'd0, 1'b0, (i == 4 || i == 8) ? 1'b1 : 1'b0);

    // A coefficient load after two samples restarts the count.
    do_reset();
    sample(16'd10, 16'd0, 1'b0, 1'b0);
    sample(16'd10, 16'd0, 1'b0, 1'b0);
    load(16'h0000, 16'd0, 1'b0);
    for (int i = 1; i <= 4; i++) sample(16'd10, 16'd0, 1'b0, (i == 4) ? 1'b1 : 1'b0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);
    check("onek_pulse_total", pulses, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
